div32_ctrl: RTL and testbench

Issue/writeback controller for the iterative 32-bit divider (`div32_nonrestoring_skip`) in the integer divide pipeline. It accepts one DIV/DIVU/REM/REMU op at a time through a ready/valid handshake. It resolves RISC-V special cases without running the divider, and otherwise sequences the divider through `clear`/`done`. It then holds the selected result until the writeback arbiter accepts it, and supports a pipeline kill at any point.

---
 rtl/core_types_pkg.sv | 32 +++
 rtl/div32_nonrestoring_skip.sv | 92 +++++++++
 rtl/div32_ctrl.sv | 168 ++++++++++++++++
 tb/tb_div32_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared types for the integer divide pipeline: op codes, controller states
// and the operand constants used for RISC-V divide special-case detection.
package core_types_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN,
    WB
  } div32_ctrl_state_t;

  localparam logic [31:0] DIV32_SIGNED_OVF_A = 32'h8000_0000;
  localparam logic [31:0] DIV32_ALL_ONES     = 32'hFFFF_FFFF;

  // Signed ops have op[0] clear (DIV, REM)
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Remainder ops have op[1] set (REM, REMU)
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div32_nonrestoring_skip.sv
// Iterative 32-bit non-restoring divider on operand magnitudes, one quotient
// bit per cycle, with sign fix-up on the final cycle. When |A| < |B| the
// iterations are skipped entirely (quotient 0, remainder A).
// `clear` (re)starts a division from A32_in/B32_in; `done` pulses one cycle
// with quotient_out/remainder_out valid. Divisor zero is never presented.
module div32_nonrestoring_skip (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        clear,
  input  logic        is_signed,
  input  logic [31:0] A32_in,
  input  logic [31:0] B32_in,
  output logic        done,
  output logic [31:0] quotient_out,
  output logic [31:0] remainder_out
);

  logic signed [33:0] rem_acc;
  logic signed [33:0] shifted;
  logic signed [33:0] stepped;
  logic        [31:0] rem_fix;
  logic        [31:0] quo;
  logic        [31:0] dvs;
  logic        [31:0] mag_a;
  logic        [31:0] mag_b;
  logic        [5:0]  cnt;
  logic               busy;
  logic               neg_q;
  logic               neg_r;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Operand magnitudes, one non-restoring step and final remainder correction
  always_comb begin
    mag_a   = magnitude(A32_in, is_signed);
    mag_b   = magnitude(B32_in, is_signed);
    shifted = {rem_acc[32:0], quo[31]};
    stepped = rem_acc[33] ? (shifted + $signed({2'b00, dvs}))
                          : (shifted - $signed({2'b00, dvs}));
    rem_fix = rem_acc[33] ? (rem_acc[31:0] + dvs) : rem_acc[31:0];
  end

  // Iteration state: load on clear, step while counting, finish with done pulse
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rem_acc       <= '0;
      quo           <= '0;
      dvs           <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      done          <= 1'b0;
      quotient_out  <= '0;
      remainder_out <= '0;
    end else if (clear) begin
      if (mag_a < mag_b) begin
        rem_acc <= $signed({2'b00, mag_a});
        quo     <= '0;
        cnt     <= 6'd0;
      end else begin
        rem_acc <= '0;
        quo     <= mag_a;
        cnt     <= 6'd32;
      end
      dvs   <= mag_b;
      neg_q <= is_signed & (A32_in[31] ^ B32_in[31]);
      neg_r <= is_signed & A32_in[31];
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (busy && (cnt != 6'd0)) begin
      rem_acc <= stepped;
      quo     <= {quo[30:0], ~stepped[33]};
      cnt     <= cnt - 6'd1;
      done    <= 1'b0;
    end else if (busy) begin
      busy          <= 1'b0;
      done          <= 1'b1;
      quotient_out  <= apply_sign(quo, neg_q);
      remainder_out <= apply_sign(rem_fix, neg_r);
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/div32_ctrl.sv
// Issue/writeback controller for the iterative 32-bit divider.
// Accepts one DIV/DIVU/REM/REMU op at a time, resolves divide-by-zero and
// signed overflow without the divider, otherwise sequences the divider via
// clear/done, and holds the result until writeback accepts it. kill abandons
// any op in flight.
// Optional macro DIV32_CTRL_REUSE_EN: keep the last completed divider result
// and answer a matching (A, B, signedness) op directly from it.
module div32_ctrl
  import core_types_pkg::*;
#(
  parameter int PR_WIDTH = 7
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [1:0]          issue_op,
  input  logic [31:0]         issue_A,
  input  logic [31:0]         issue_B,
  input  logic [PR_WIDTH-1:0] issue_dest_PR,
  input  logic                kill,
  output logic                WB_valid,
  input  logic                WB_ready,
  output logic [31:0]         WB_data,
  output logic [PR_WIDTH-1:0] WB_dest_PR
);

  div32_ctrl_state_t state, state_nxt;

  logic [1:0]          op_q;
  logic [31:0]         a_q;
  logic [31:0]         b_q;
  logic [PR_WIDTH-1:0] tag_q;
  logic [31:0]         wb_data_q;

  logic        accept;
  logic        fast_path;
  logic [31:0] fast_q;
  logic [31:0] fast_r;
  logic        div_clear;
  logic        div_done;
  logic [31:0] div_q;
  logic [31:0] div_r;

`ifdef DIV32_CTRL_REUSE_EN
  logic [31:0] cache_a;
  logic [31:0] cache_b;
  logic        cache_sgn;
  logic [31:0] cache_q;
  logic [31:0] cache_r;
  logic        cache_vld;
`endif

  assign accept     = (state == IDLE) && issue_valid && !kill;
  assign WB_data    = wb_data_q;
  assign WB_dest_PR = tag_q;

  // Ops answerable on cycle 1 without running the divider
  always_comb begin
    fast_path = 1'b0;
    fast_q    = '0;
    fast_r    = '0;
    if (issue_B == '0) begin
      fast_path = 1'b1;
      fast_q    = DIV32_ALL_ONES;
      fast_r    = issue_A;
    end else if (op_is_signed(issue_op) && (issue_A == DIV32_SIGNED_OVF_A) &&
                 (issue_B == DIV32_ALL_ONES)) begin
      fast_path = 1'b1;
      fast_q    = DIV32_SIGNED_OVF_A;
      fast_r    = '0;
    end
`ifdef DIV32_CTRL_REUSE_EN
    else if (cache_vld && (issue_A == cache_a) && (issue_B == cache_b) &&
             (cache_sgn == op_is_signed(issue_op))) begin
      fast_path = 1'b1;
      fast_q    = cache_q;
      fast_r    = cache_r;
    end
`endif
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and state-decoded outputs; kill overrides every transition
  always_comb begin
    state_nxt   = state;
    issue_ready = 1'b0;
    WB_valid    = 1'b0;
    div_clear   = 1'b0;
    case (state)
      IDLE: begin
        issue_ready = 1'b1;
        if (accept) state_nxt = fast_path ? WB : START;
      end
      START: begin
        div_clear = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (div_done) state_nxt = WB;
      end
      WB: begin
        WB_valid = 1'b1;
        if (WB_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (kill) state_nxt = IDLE;
  end

  // Operand/tag latch at issue and result capture on entry to WB
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      tag_q     <= '0;
      wb_data_q <= '0;
    end else if (accept) begin
      op_q  <= issue_op;
      a_q   <= issue_A;
      b_q   <= issue_B;
      tag_q <= issue_dest_PR;
      if (fast_path) wb_data_q <= op_is_rem(issue_op) ? fast_r : fast_q;
    end else if ((state == RUN) && div_done && !kill) begin
      wb_data_q <= op_is_rem(op_q) ? div_r : div_q;
    end
  end

`ifdef DIV32_CTRL_REUSE_EN
  // Remember the last completed divider result; only reset clears it
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cache_a   <= '0;
      cache_b   <= '0;
      cache_sgn <= 1'b0;
      cache_q   <= '0;
      cache_r   <= '0;
      cache_vld <= 1'b0;
    end else if ((state == RUN) && div_done && !kill) begin
      cache_a   <= a_q;
      cache_b   <= b_q;
      cache_sgn <= op_is_signed(op_q);
      cache_q   <= div_q;
      cache_r   <= div_r;
      cache_vld <= 1'b1;
    end
  end
`endif

  div32_nonrestoring_skip u_div (
    .CLK          (CLK),
    .nRST         (nRST),
    .clear        (div_clear),
    .is_signed    (op_is_signed(op_q)),
    .A32_in       (a_q),
    .B32_in       (b_q),
    .done         (div_done),
    .quotient_out (div_q),
    .remainder_out(div_r)
  );

endmodule

// File: tb/tb_div32_ctrl.sv
// Scoreboard bench for div32_ctrl: expected results are queued at issue and
// a negedge monitor pops/compares on every WB handshake.
module tb_div32_ctrl;
  import core_types_pkg::*;

  localparam int PR_WIDTH = 7;

  logic                CLK = 1'b0;
  logic                nRST = 1'b0;
  logic                issue_valid = 1'b0;
  logic                issue_ready;
  logic [1:0]          issue_op = 2'b00;
  logic [31:0]         issue_A = '0;
  logic [31:0]         issue_B = '0;
  logic [PR_WIDTH-1:0] issue_dest_PR = '0;
  logic                kill = 1'b0;
  logic                WB_valid;
  logic                WB_ready = 1'b1;
  logic [31:0]         WB_data;
  logic [PR_WIDTH-1:0] WB_dest_PR;

  typedef struct packed {
    logic [31:0]         data;
    logic [PR_WIDTH-1:0] tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  div32_ctrl #(.PR_WIDTH(PR_WIDTH)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_op     (issue_op),
    .issue_A      (issue_A),
    .issue_B      (issue_B),
    .issue_dest_PR(issue_dest_PR),
    .kill         (kill),
    .WB_valid     (WB_valid),
    .WB_ready     (WB_ready),
    .WB_data      (WB_data),
    .WB_dest_PR   (WB_dest_PR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted writeback must match the head of the scoreboard
  always @(negedge CLK) begin
    if (nRST && WB_valid && WB_ready && !kill) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wb", 32'(WB_data), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("wb_data", WB_data, e.data);
        check("wb_dest_pr", 32'(WB_dest_PR), 32'(e.tag));
      end
    end
  end

  // Drive one issue; returns #1 after the accepting edge (cycle 1)
  task automatic drive_issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [PR_WIDTH-1:0] tag);
    @(posedge CLK); #1;
    check("issue_ready_before_issue", 32'(issue_ready), 32'd1);
    issue_valid   = 1'b1;
    issue_op      = op;
    issue_A       = a;
    issue_B       = b;
    issue_dest_PR = tag;
    @(posedge CLK); #1;
    issue_valid = 1'b0;
  endtask

  // Full op with expected result; special ops must show WB_valid on cycle 1
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [PR_WIDTH-1:0] tag, input logic [31:0] exp_data,
                        input bit special);
    int   n;
    logic prev_done;
    sb_q.push_back({exp_data, tag});
    drive_issue(op, a, b, tag);
    if (special) begin
      check("fast_wb_valid_cycle1", 32'(WB_valid), 32'd1);
      check("fast_no_clear", 32'(dut.div_clear), 32'd0);
    end else begin
      check("clear_cycle1", 32'(dut.div_clear), 32'd1);
      @(posedge CLK); #1;
      check("clear_one_cycle", 32'(dut.div_clear), 32'd0);
      n = 0;
      prev_done = 1'b0;
      while (!WB_valid && n < 100) begin
        prev_done = dut.u_div.done;
        @(posedge CLK); #1;
        n++;
      end
      check("wb_within_budget", 32'(n < 100), 32'd1);
      check("wb_after_done", 32'(prev_done), 32'd1);
    end
    if (WB_ready) begin
      @(posedge CLK); #1;
      check("idle_after_wb", 32'(issue_ready), 32'd1);
      check("wb_valid_dropped", 32'(WB_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_valid;
    bit saw_done;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_wb_valid", 32'(WB_valid), 32'd0);
    check("rst_wb_data", WB_data, 32'd0);
    check("rst_wb_dest", 32'(WB_dest_PR), 32'd0);
    check("rst_clear", 32'(dut.div_clear), 32'd0);
    nRST = 1'b1;

    // Normal divides
    run_op(DIV,  32'd100, 32'd7, 7'd5, 32'd14, 1'b0);
    run_op(REMU, 32'd100, 32'd7, 7'd6, 32'd2,  1'b0);

    // Special cases
    run_op(DIVU, 32'h0000_1234, 32'h0000_0000, 7'd7, 32'hFFFF_FFFF, 1'b1);
    run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 7'd8, 32'h0000_0000, 1'b1);

    // Signed operands
    run_op(DIV, 32'hFFFF_FFEC, 32'd3, 7'd9, 32'hFFFF_FFFA, 1'b0);
`ifdef DIV32_CTRL_REUSE_EN
    run_op(REM, 32'hFFFF_FFEC, 32'd3, 7'd10, 32'hFFFF_FFFE, 1'b1);
`else
    run_op(REM, 32'hFFFF_FFEC, 32'd3, 7'd10, 32'hFFFF_FFFE, 1'b0);
`endif

    // Kill two cycles into RUN; the divider's later done must be ignored
    drive_issue(DIV, 32'd1000, 32'd3, 7'd11);
    repeat (3) begin @(posedge CLK); #1; end
    kill = 1'b1;
    @(posedge CLK); #1;
    kill = 1'b0;
    check("kill_to_idle", 32'(issue_ready), 32'd1);
    check("kill_no_wb", 32'(WB_valid), 32'd0);
    saw_valid = 1'b0;
    saw_done  = 1'b0;
    repeat (45) begin
      @(posedge CLK); #1;
      saw_valid |= WB_valid;
      saw_done  |= dut.u_div.done;
    end
    check("stray_done_seen", 32'(saw_done), 32'd1);
    check("stray_done_ignored", 32'(saw_valid), 32'd0);
    run_op(DIVU, 32'd9, 32'd2, 7'd12, 32'd4, 1'b0);

    // Writeback backpressure
    WB_ready = 1'b0;
    run_op(DIV, 32'd100, 32'd7, 7'd13, 32'd14, 1'b0);
    repeat (5) begin
      @(posedge CLK); #1;
      check("bp_wb_valid", 32'(WB_valid), 32'd1);
      check("bp_wb_data", WB_data, 32'd14);
      check("bp_wb_dest", 32'(WB_dest_PR), 32'd13);
      check("bp_issue_ready", 32'(issue_ready), 32'd0);
    end
    WB_ready = 1'b1;
    @(posedge CLK); #1;
    check("bp_release_idle", 32'(issue_ready), 32'd1);

    // Asynchronous reset mid-operation
    drive_issue(DIVU, 32'd5000, 32'd7, 7'd14);
    repeat (3) begin @(posedge CLK); #1; end
    #2;
    nRST = 1'b0;
    #1;
    check("arst_issue_ready", 32'(issue_ready), 32'd1);
    check("arst_wb_valid", 32'(WB_valid), 32'd0);
    check("arst_wb_data", WB_data, 32'd0);
    check("arst_wb_dest", 32'(WB_dest_PR), 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    repeat (5) @(posedge CLK);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
